pmem_line_responder: RTL

PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

---
 rtl/lc3b_types.sv | 13 +
 rtl/pmem_line_array.sv | 31 +++
 rtl/pmem_line_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory types and the line-responder state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } pmem_resp_state;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: synchronous write, combinational read, synchronous clear.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  cache_line        i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output cache_line        o_rdata
);

  localparam int DEPTH = 1 << IDX_W;

  cache_line r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency physical-memory line responder for the LC-3b cache.
// Optional completion counters: define PMEM_RESP_STATS_EN.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int RESP_LATENCY = 4,
  parameter int LINE_IDX_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  cache_line   pmem_wdata,
  output cache_line   pmem_rdata,
  output logic        pmem_resp,
  output logic        busy,
  output logic        protocol_err,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  pmem_resp_state r_state;
  pmem_resp_state w_next;

  logic [LINE_IDX_W-1:0] r_idx;
  cache_line             r_wdata;
  logic                  r_op_wr;
  logic [3:0]            r_cnt;
  logic                  r_err;

  logic      w_req;
  logic      w_accept;
  logic      w_abort;
  logic      w_resp;
  logic      w_we;
  cache_line w_line;

  logic w_unused;
  assign w_unused = ^{pmem_address[3:0], pmem_address[15:LINE_IDX_W+4]};

  assign w_req = pmem_read | pmem_write;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_abort  = 1'b0;
    w_resp   = 1'b0;
    w_we     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_req) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_resp = 1'b1;
        w_we   = r_op_wr;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= pmem_address[LINE_IDX_W+3:4];
        r_wdata <= pmem_wdata;
        r_op_wr <= pmem_write;
        r_cnt   <= 4'(RESP_LATENCY - 2);
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Sticky: only reset clears a reported violation.
      if ((w_accept && pmem_read && pmem_write) || w_abort)
        r_err <= 1'b1;
    end
  end

  pmem_line_array #(
    .IDX_W(LINE_IDX_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_waddr(r_idx),
    .i_wdata(r_wdata),
    .i_raddr(r_idx),
    .o_rdata(w_line)
  );

  assign pmem_resp    = w_resp;
  assign pmem_rdata   = (w_resp && !r_op_wr) ? w_line : '0;
  assign busy         = (r_state != S_IDLE);
  assign protocol_err = r_err;

`ifdef PMEM_RESP_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_resp) begin
      if (!r_op_wr && r_rd_cnt != 16'hFFFF)
        r_rd_cnt <= r_rd_cnt + 16'd1;
      if (r_op_wr && r_wr_cnt != 16'hFFFF)
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign read_count  = r_rd_cnt;
  assign write_count = r_wr_cnt;
`else
  assign read_count  = '0;
  assign write_count = '0;
`endif

endmodule
